// File: rtl/cg_timer_pkg.sv
// Shared types and defaults for the CommonGoods countdown timer.
package cg_timer_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_t;

endpackage

// File: rtl/cg_countdown_timer.sv
// Loadable down-counting timer with one-shot / auto-reload modes and pause/resume.
// All outputs come straight from registers.
module cg_countdown_timer
    import cg_timer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_value,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_auto_reload,
    output logic [DATA_WIDTH-1:0] o_count,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_expire
);

    localparam logic [DATA_WIDTH-1:0] ONE  = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] ZERO = '0;

    timer_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] reload_q, reload_d;
    logic                  expire_q, expire_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q  <= ZERO;
            reload_q <= ZERO;
            expire_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            expire_q <= expire_d;
        end
    end

    // Load aborts everything; within a state, stop outranks start.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        expire_d = 1'b0;
        if (i_load) begin
            reload_d = i_value;
            count_d  = i_value;
            state_d  = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_start && (count_q != ZERO)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (i_stop) begin
                        state_d = PAUSE;
                    end else if (count_q == ONE) begin
                        expire_d = 1'b1;
                        if (i_auto_reload) begin
                            count_d = reload_q;
                        end else begin
                            count_d = ZERO;
                            state_d = DONE;
                        end
                    end else if (count_q != ZERO) begin
                        count_d = count_q - ONE;
                    end
                end
                PAUSE: begin
                    if (!i_stop && i_start) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    if (i_start && (reload_q != ZERO)) begin
                        count_d = reload_q;
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_count  = count_q;
        o_expire = expire_q;
        o_busy   = (state_q == RUN);
        o_done   = (state_q == DONE);
    end

endmodule

// File: tb/tb_cg_countdown_timer.sv
// Self-checking bench for cg_countdown_timer: directed scenarios plus a
// randomized run checked against a behavioural model.
module tb_cg_countdown_timer;

    localparam int W = 32;

    logic         i_clk = 1'b0;
    logic         i_rst, i_load, i_start, i_stop, i_auto_reload;
    logic [W-1:0] i_value;
    logic [W-1:0] o_count;
    logic         o_busy, o_done, o_expire;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: mode 0 idle, 1 running, 2 paused, 3 finished.
    int           m_mode;
    logic [W-1:0] m_count, m_reload;
    logic         m_expire;

    cg_countdown_timer #(.DATA_WIDTH(W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_load(i_load), .i_value(i_value),
        .i_start(i_start), .i_stop(i_stop), .i_auto_reload(i_auto_reload),
        .o_count(o_count), .o_busy(o_busy), .o_done(o_done), .o_expire(o_expire)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_rst = 0; i_load = 0; i_start = 0; i_stop = 0; i_auto_reload = 0; i_value = '0;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        i_load = 1; i_value = v; tick(); i_load = 0;
    endtask

    task automatic do_start();
        i_start = 1; tick(); i_start = 0;
    endtask

    task automatic model_step();
        logic counting;
        m_expire = 0;
        counting = (m_mode == 1) && !i_stop;
        if (i_rst) begin
            m_mode = 0; m_count = 0; m_reload = 0;
        end else if (i_load) begin
            m_mode = 0; m_count = i_value; m_reload = i_value;
        end else if (m_mode == 1 && i_stop) begin
            m_mode = 2;
        end else if (counting) begin
            if (m_count == 1) begin
                m_expire = 1;
                if (i_auto_reload) m_count = m_reload;
                else begin m_count = 0; m_mode = 3; end
            end else if (m_count > 1) begin
                m_count = m_count - 1;
            end
        end else if (i_start && !(m_mode == 2 && i_stop)) begin
            if (m_mode == 0 && m_count != 0) m_mode = 1;
            else if (m_mode == 2) m_mode = 1;
            else if (m_mode == 3 && m_reload != 0) begin
                m_count = m_reload; m_mode = 1;
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        i_rst = 1; i_load = 1; i_value = 32'hDEAD_BEEF; i_start = 1;
        tick(); tick();
        idle_inputs();
        n_cmp++; if (o_count !== '0) begin n_fail++; $display("[TB] FAIL reset_count got %h want 0", o_count); end
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", o_busy); end
        n_cmp++; if (o_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got %b want 0", o_done); end
        n_cmp++; if (o_expire !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_expire got %b want 0", o_expire); end
        do_start();
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_start_at_zero busy got %b want 0", o_busy); end
    endtask

    task automatic test_one_shot();
        logic [W-1:0] exp_seq [6] = '{5, 4, 3, 2, 1, 0};
        do_load(5);
        do_start();
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (o_count !== exp_seq[i]) begin n_fail++; $display("[TB] FAIL oneshot_count[%0d] got %0d want %0d", i, o_count, exp_seq[i]); end
            n_cmp++; if (o_expire !== (i == 5)) begin n_fail++; $display("[TB] FAIL oneshot_expire[%0d] got %b want %b", i, o_expire, (i == 5)); end
            if (i < 5) tick();
        end
        n_cmp++; if (o_done !== 1'b1 || o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL oneshot_flags got done=%b busy=%b want done=1 busy=0", o_done, o_busy); end
        tick(); tick();
        n_cmp++; if (o_count !== '0 || o_expire !== 1'b0) begin n_fail++; $display("[TB] FAIL oneshot_hold got count=%0d expire=%b want 0/0", o_count, o_expire); end
    endtask

    task automatic test_auto_reload();
        logic [W-1:0] exp_seq [9] = '{3, 2, 1, 3, 2, 1, 3, 2, 1};
        do_load(3);
        i_auto_reload = 1;
        do_start();
        for (int i = 0; i < 9; i++) begin
            n_cmp++; if (o_count !== exp_seq[i]) begin n_fail++; $display("[TB] FAIL auto_count[%0d] got %0d want %0d", i, o_count, exp_seq[i]); end
            n_cmp++; if (o_expire !== (i == 3 || i == 6)) begin n_fail++; $display("[TB] FAIL auto_expire[%0d] got %b want %b", i, o_expire, (i == 3 || i == 6)); end
            n_cmp++; if (o_done !== 1'b0) begin n_fail++; $display("[TB] FAIL auto_done[%0d] got %b want 0", i, o_done); end
            tick();
        end
        i_auto_reload = 0;
    endtask

    task automatic test_pause_resume();
        int seen_at;
        do_load(10);
        do_start();
        for (int i = 0; i < 4; i++) tick();
        i_stop = 1; tick(); i_stop = 0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (o_count !== 6 || o_busy !== 1'b0 || o_expire !== 1'b0) begin
                n_fail++; $display("[TB] FAIL pause_hold[%0d] got count=%0d busy=%b expire=%b want 6/0/0", i, o_count, o_busy, o_expire);
            end
            tick();
        end
        do_start();
        n_cmp++; if (o_count !== 6 || o_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL resume got count=%0d busy=%b want 6/1", o_count, o_busy); end
        seen_at = -1;
        for (int i = 1; i <= 10 && seen_at < 0; i++) begin
            tick();
            if (o_expire) seen_at = i;
        end
        n_cmp++; if (seen_at != 6) begin n_fail++; $display("[TB] FAIL resume_latency got %0d want 6", seen_at); end
    endtask

    task automatic test_load_abort();
        do_load(20);
        do_start();
        for (int i = 0; i < 13; i++) tick();
        n_cmp++; if (o_count !== 7) begin n_fail++; $display("[TB] FAIL abort_pre got %0d want 7", o_count); end
        do_load(32'h0404_0202);
        n_cmp++; if (o_count !== 32'h0404_0202 || o_busy !== 1'b0 || o_done !== 1'b0 || o_expire !== 1'b0) begin
            n_fail++; $display("[TB] FAIL abort_load got count=%h busy=%b done=%b expire=%b want 04040202/0/0/0", o_count, o_busy, o_done, o_expire);
        end
        do_start();
        tick();
        n_cmp++; if (o_count !== 32'h0404_0201 || o_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_restart got count=%h busy=%b want 04040201/1", o_count, o_busy); end
    endtask

    task automatic test_reset_with_load();
        do_load(5);
        do_start();
        tick(); tick();
        n_cmp++; if (o_count !== 3) begin n_fail++; $display("[TB] FAIL rstload_pre got %0d want 3", o_count); end
        i_rst = 1; i_load = 1; i_value = 99; tick(); idle_inputs();
        n_cmp++; if (o_count !== '0 || o_busy !== 1'b0 || o_expire !== 1'b0) begin
            n_fail++; $display("[TB] FAIL rstload got count=%0d busy=%b expire=%b want 0/0/0", o_count, o_busy, o_expire);
        end
        do_start();
        n_cmp++; if (o_count !== '0 || o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rstload_start got count=%0d busy=%b want 0/0", o_count, o_busy); end
    endtask

    task automatic test_back_to_back();
        int seen_at;
        do_load(8);
        do_start();
        tick();
        i_start = 1; i_stop = 1; tick(); i_start = 0; i_stop = 0;
        n_cmp++; if (o_count !== 7 || o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL startstop got count=%0d busy=%b want 7/0", o_count, o_busy); end
        do_load(4);
        do_start();
        for (int i = 0; i < 4; i++) tick();
        n_cmp++; if (o_done !== 1'b1) begin n_fail++; $display("[TB] FAIL restart_pre done got %b want 1", o_done); end
        do_start();
        n_cmp++; if (o_count !== 4 || o_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL restart got count=%0d busy=%b want 4/1", o_count, o_busy); end
        seen_at = -1;
        for (int i = 1; i <= 8 && seen_at < 0; i++) begin
            tick();
            if (o_expire) seen_at = i;
        end
        n_cmp++; if (seen_at != 4) begin n_fail++; $display("[TB] FAIL restart_latency got %0d want 4", seen_at); end
    endtask

    task automatic test_boundaries();
        do_load('1);
        do_start();
        tick();
        n_cmp++; if (o_count !== 32'hFFFF_FFFE) begin n_fail++; $display("[TB] FAIL allones got %h want fffffffe", o_count); end
        do_load(1);
        i_auto_reload = 1;
        do_start();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (o_count !== 1 || o_expire !== 1'b1 || o_busy !== 1'b1) begin
                n_fail++; $display("[TB] FAIL period1[%0d] got count=%0d expire=%b busy=%b want 1/1/1", i, o_count, o_expire, o_busy);
            end
        end
        i_auto_reload = 0;
        tick();
        n_cmp++; if (o_count !== 0 || o_done !== 1'b1) begin n_fail++; $display("[TB] FAIL period1_stop got count=%0d done=%b want 0/1", o_count, o_done); end
    endtask

    task automatic test_random();
        idle_inputs();
        i_rst = 1; tick(); i_rst = 0;
        m_mode = 0; m_count = 0; m_reload = 0; m_expire = 0;
        for (int c = 0; c < 3000; c++) begin
            i_rst         = ($urandom_range(0, 199) == 0);
            i_load        = ($urandom_range(0, 24) == 0);
            i_value       = ($urandom_range(0, 31) == 0) ? '1 : W'($urandom_range(0, 7));
            i_start       = ($urandom_range(0, 4) == 0);
            i_stop        = ($urandom_range(0, 9) == 0);
            i_auto_reload = $urandom_range(0, 1);
            model_step();
            tick();
            n_cmp++; if (o_count !== m_count || o_expire !== m_expire || o_busy !== (m_mode == 1) || o_done !== (m_mode == 3)) begin
                n_fail++;
                $display("[TB] FAIL random[%0d] got count=%h expire=%b busy=%b done=%b want %h/%b/%b/%b",
                         c, o_count, o_expire, o_busy, o_done, m_count, m_expire, (m_mode == 1), (m_mode == 3));
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        i_rst = 1;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_pause_resume();
        test_load_abort();
        test_reset_with_load();
        test_back_to_back();
        test_boundaries();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cg_countdown_timer.md
Name: cg_countdown_timer

Overview:
Loadable down-counting timer, complementary to the free-running up-counter: counts a programmed value down to zero and signals expiry. It supports one-shot and auto-reload (periodic tick) modes, plus pause and resume. It is the standard timeout and tick source for CommonGoods consumers such as watchdogs, bus timeouts and periodic strobes.

Parameters:
DATA_WIDTH, 32, width of the count, reload value and i_value.

Ports:
i_clk  in  1  clock; all state changes on the rising edge.
i_rst  in  1  synchronous, active-high reset.
i_load  in  1  load i_value into the reload register and count; aborts any run.
i_value  in  DATA_WIDTH  value captured by i_load.
i_start  in  1  start from IDLE, resume from PAUSE, or restart from DONE.
i_stop  in  1  pause while running.
i_auto_reload  in  1  periodic mode, sampled at the expiry edge.
o_count  out  DATA_WIDTH  current count (registered).
o_busy  out  1  high while state is RUN.
o_done  out  1  high while state is DONE.
o_expire  out  1  single-cycle pulse on every expiry.

Behaviour:
- States: IDLE, RUN, PAUSE, DONE. Registers: state, o_count, reload_reg, o_expire. All outputs are registered.
- Reset (i_rst=1 at an edge): state=IDLE, o_count=0, reload_reg=0, o_expire=0, o_busy=0, o_done=0. Reset overrides every other input.
- Priority per edge: i_rst > i_load > i_stop > i_start > normal counting.
- i_load in any state: reload_reg<=i_value, o_count<=i_value, state<=IDLE. No o_expire pulse, even if RUN was at count 1.
- IDLE + i_start:
  - o_count!=0: state<=RUN, count unchanged on this edge.
  - o_count==0: ignored, stay IDLE.
- RUN, count>1: o_count<=o_count-1 each edge.
- RUN, count==1:
  - o_expire<=1 for one cycle.
  - If i_auto_reload=1: o_count<=reload_reg, stay RUN. Period = reload_reg cycles; the count sequence is N..1 and 0 is never shown.
  - Otherwise: o_count<=0, state<=DONE.
- RUN + i_stop: state<=PAUSE, count held on this edge with no decrement. If i_stop and i_start are asserted together, i_stop wins.
- PAUSE + i_start: state<=RUN, count held on this edge. PAUSE + i_stop: no change.
- DONE + i_start:
  - reload_reg!=0: o_count<=reload_reg, state<=RUN.
  - reload_reg==0: ignored.
- IDLE, DONE + i_stop: no effect.
- Latency: a start edge with count N gives o_expire high in the cycle after the N-th following edge, i.e. N cycles after RUN is entered.
- Wrap-around: the counter never decrements below 0 and never underflows. A reload value of 0 with i_auto_reload is impossible, because IDLE refuses to start at 0.
- Edge widths: the count is unsigned DATA_WIDTH. All-ones is a valid load value, giving a period of 2^DATA_WIDTH-1 cycles.
- i_auto_reload may change at any time; only its value at the count==1 edge matters.

Decomposition:
- Shared package cg_timer_pkg holds:
  - the state enum typedef (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3);
  - the localparam default DATA_WIDTH.
- No sub-module: FSM and decrementer sit in one module of about 150 lines.

Test Plan:
1. Reset, load 5, start, auto_reload=0 -> o_count 5,4,3,2,1,0 on successive edges; o_expire high exactly one cycle coincident with count 0; then o_done=1, o_busy=0, count stays 0.
2. Load 3, auto_reload=1, start -> count cycles 3,2,1,3,2,1,...; o_expire pulses every 3 cycles; o_done never asserts.
3. Load 10, start; stop when count=6; hold 5 cycles -> count stays 6, o_busy=0. Start again -> expire 6 cycles later, with no expire while paused.
4. Running at count 7, i_load with i_value=32'h0404_0202 -> o_count=32'h0404_0202, state IDLE, no o_expire. A later start counts down from that value.
5. i_rst and i_load asserted together mid-run at count 3 -> o_count=0, IDLE, reload_reg=0, no expire. A subsequent start is ignored (count 0).
6. i_start and i_stop asserted together in RUN -> PAUSE with count held. From DONE with reload_reg=4, start -> count 4 and RUN, expire after 4 further edges.
